data_memory_dma: RTL

DATA_MEMORY_DMA -- requirements
Module: data_memory_dma

---
 rtl/data_memory_dma.sv | 105 ++++++++++
 1 files changed

// File: rtl/data_memory_dma.sv
// data_memory_dma: data memory with a CPU port and a DMA burst-write engine.
// Latency: rd is combinational from a; writes land on the next posedge. Define DMEM_LOC0_ZERO_EN to hardwire word 0 to zero.
// Backpressure: dma_ready drops while the CPU writes; the DMA beat waits and no data is lost.
module data_memory_dma #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] rd,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_base,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic              dma_valid,
  input  logic [DATA_W-1:0] dma_data,
  output logic              dma_ready,
  output logic              dma_busy,
  output logic              dma_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  cnt;
  logic              load;
  logic              beat;
  logic              loc0_cpu;
  logic              loc0_dma;

`ifdef DMEM_LOC0_ZERO_EN
  assign loc0_cpu = (a == '0);
  assign loc0_dma = (ptr == '0);
  assign rd       = loc0_cpu ? '0 : mem[a];
`else
  assign loc0_cpu = 1'b0;
  assign loc0_dma = 1'b0;
  assign rd       = mem[a];
`endif

  assign beat = dma_valid && dma_ready;

  // Outputs are masked while rst is held so a burst being aborted never shows ready/busy/done.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    dma_ready = 1'b0;
    dma_busy  = 1'b0;
    dma_done  = 1'b0;
    case (state)
      IDLE: begin
        if (dma_start) begin
          if (dma_len != '0) begin
            state_nxt = BURST;
            load      = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      BURST: begin
        dma_busy  = !rst;
        dma_ready = !we && !rst;
        if (dma_valid && !we && cnt == LEN_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        dma_done  = !rst;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        ptr <= dma_base;
        cnt <= dma_len;
      end else if (beat) begin
        ptr <= ptr + 1'b1;
        cnt <= cnt - 1'b1;
      end
      // CPU owns the write port; a DMA beat can only land when we is low.
      if (we) begin
        if (!loc0_cpu) mem[a] <= wd;
      end else if (beat && !loc0_dma) begin
        mem[ptr] <= dma_data;
      end
    end
  end

endmodule
